// File: rtl/gpu_cmd_pkg.sv
// gpu_cmd_pkg: shared command layout constants and scheduler state encoding
package gpu_cmd_pkg;
  localparam int CMD_W = 128;
  localparam int SHAPE_MSB = 127;
  localparam int SHAPE_LSB = 124;
  localparam logic [3:0] SHAPE_NOP = 4'd0;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO with wrap-around pointers, flush and occupancy count
module cmd_fifo #(
  parameter int W = 128,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full && !flush;
  assign do_pop = pop && !empty && !flush;
  assign dout = mem[rd];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wr] <= din;
endmodule

// File: rtl/draw_cmd_scheduler.sv
// draw_cmd_scheduler: queues host draw commands and issues them one at a time,
// waiting for engine completion with a watchdog between issues.
module draw_cmd_scheduler
  import gpu_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W = 16,
  localparam int QW = $clog2(DEPTH) + 1,
  localparam int TW = $clog2(TIMEOUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             host_valid,
  output logic             host_ready,
  input  logic [CMD_W-1:0] host_data,
  output logic             cmd_valid,
  output logic [CMD_W-1:0] cmd_data,
  input  logic             engine_done,
  input  logic             flush,
  input  logic             err_clr,
  output logic             busy,
  output logic [QW-1:0]    queue_count,
  output logic [CNT_W-1:0] done_count,
  output logic             err_timeout
);
  state_t state, state_d;
  logic [CMD_W-1:0] head;
  logic [TW-1:0] timer;
  logic full, empty, pop, issue, fin, tmo;
  cmd_fifo #(.W(CMD_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(host_valid && host_ready), .pop(pop), .flush(flush),
    .din(host_data), .dout(head), .count(queue_count), .full(full), .empty(empty)
  );
  assign host_ready = !full && !flush;
  assign busy = state != IDLE || !empty;
  // A flushing cycle neither issues nor drops: the queue is being discarded.
  always_comb begin
    state_d = state;
    pop = 1'b0;
    issue = 1'b0;
    fin = 1'b0;
    tmo = 1'b0;
    case (state)
      IDLE: if (!empty && !flush) begin
        pop = 1'b1;
        issue = head[SHAPE_MSB:SHAPE_LSB] != SHAPE_NOP;
        state_d = issue ? ISSUE : IDLE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        fin = engine_done;
        tmo = !engine_done && timer == TW'(TIMEOUT - 1);
        state_d = fin || tmo ? IDLE : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cmd_valid <= 1'b0;
      cmd_data <= '0;
      timer <= '0;
      done_count <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_d;
      cmd_valid <= issue;
      if (issue) cmd_data <= head;
      timer <= state == WAIT && !fin && !tmo ? timer + 1'b1 : '0;
      done_count <= done_count + CNT_W'(fin);
      err_timeout <= tmo || (err_timeout && !err_clr);
    end
  end
endmodule

// File: tb/tb_draw_cmd_scheduler.sv
// tb_draw_cmd_scheduler: directed checks of issue latency, ordering, NOP drop,
// watchdog, flush and asynchronous reset (DEPTH=4, TIMEOUT=8).
module tb_draw_cmd_scheduler;
  logic clk = 0, rst = 1, host_valid = 0, engine_done = 0, flush = 0, err_clr = 0;
  logic [127:0] host_data = '0;
  logic host_ready, cmd_valid, busy, err_timeout;
  logic [127:0] cmd_data;
  logic [2:0] queue_count;
  logic [15:0] done_count;
  int tests = 0, fails = 0;

  draw_cmd_scheduler #(.DEPTH(4), .TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .host_valid(host_valid), .host_ready(host_ready),
    .host_data(host_data), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .engine_done(engine_done), .flush(flush), .err_clr(err_clr), .busy(busy),
    .queue_count(queue_count), .done_count(done_count), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mk(input logic [3:0] shape, input int tag);
    return {shape, 92'd0, 32'(tag)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [127:0] d);
    host_valid = 1;
    host_data = d;
    step();
    host_valid = 0;
  endtask

  task automatic expect_issue(input string tag, input logic [127:0] d);
    for (int i = 0; i < 20 && !cmd_valid; i++) step();
    chk({tag, "_valid"}, 128'(cmd_valid), 128'(1));
    chk({tag, "_data"}, cmd_data, d);
    step();
    engine_done = 1;
    step();
    engine_done = 0;
  endtask

  initial begin
    logic [127:0] c1, a[6], x, nop, rect, t1, t2, t3;
    int seen;
    c1 = {4'h1, 8'h0A, 8'h14, 8'h32, 8'h3C, 92'd1};
    for (int i = 0; i < 6; i++) a[i] = mk(4'h2, 16 + i);
    x = mk(4'h3, 40);
    nop = mk(4'h0, 41);
    rect = mk(4'h2, 42);
    t1 = mk(4'h4, 50);
    t2 = mk(4'h5, 51);
    t3 = mk(4'h6, 52);

    #3;
    chk("rst_valid", 128'(cmd_valid), 128'(0));
    chk("rst_data", cmd_data, 128'(0));
    chk("rst_qc", 128'(queue_count), 128'(0));
    chk("rst_done", 128'(done_count), 128'(0));
    chk("rst_err", 128'(err_timeout), 128'(0));
    chk("rst_ready", 128'(host_ready), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    step();
    step();
    rst = 0;
    step();

    // single command: latency, data, completion
    push(c1);
    chk("t1_qc", 128'(queue_count), 128'(1));
    chk("t1_novalid", 128'(cmd_valid), 128'(0));
    chk("t1_busy", 128'(busy), 128'(1));
    step();
    chk("t1_valid", 128'(cmd_valid), 128'(1));
    chk("t1_data", cmd_data, c1);
    step();
    chk("t1_pulse", 128'(cmd_valid), 128'(0));
    chk("t1_hold", cmd_data, c1);
    step();
    step();
    chk("t1_wait_busy", 128'(busy), 128'(1));
    engine_done = 1;
    step();
    engine_done = 0;
    chk("t1_done", 128'(done_count), 128'(1));
    chk("t1_idle", 128'(busy), 128'(0));
    engine_done = 1;
    step();
    engine_done = 0;
    chk("idle_done_ignored", 128'(done_count), 128'(1));

    // back-to-back pushes until full, one in flight
    for (int i = 0; i < 5; i++) begin
      host_valid = 1;
      host_data = a[i];
      step();
    end
    chk("t2_full_ready", 128'(host_ready), 128'(0));
    chk("t2_full_qc", 128'(queue_count), 128'(4));
    host_data = a[5];
    step();
    chk("t2_refused_qc", 128'(queue_count), 128'(4));
    engine_done = 1;
    step();
    engine_done = 0;
    chk("t2_a0_done", 128'(done_count), 128'(2));
    step();
    chk("t2_a1_valid", 128'(cmd_valid), 128'(1));
    chk("t2_a1_data", cmd_data, a[1]);
    chk("t2_pop_qc", 128'(queue_count), 128'(3));
    chk("t2_pop_ready", 128'(host_ready), 128'(1));
    step();
    host_valid = 0;
    chk("t2_accept_qc", 128'(queue_count), 128'(4));
    engine_done = 1;
    step();
    engine_done = 0;
    expect_issue("t2_a2", a[2]);
    expect_issue("t2_a3", a[3]);
    expect_issue("t2_a4", a[4]);
    expect_issue("t2_a5", a[5]);
    chk("t2_done", 128'(done_count), 128'(7));
    chk("t2_empty", 128'(queue_count), 128'(0));
    chk("t2_busy", 128'(busy), 128'(0));

    // NOP is dropped, rect is issued
    host_valid = 1;
    host_data = x;
    step();
    host_data = nop;
    step();
    host_data = rect;
    step();
    host_valid = 0;
    chk("t3_qc2", 128'(queue_count), 128'(2));
    engine_done = 1;
    step();
    engine_done = 0;
    chk("t3_x_done", 128'(done_count), 128'(8));
    step();
    chk("t3_qc1", 128'(queue_count), 128'(1));
    chk("t3_nop_novalid", 128'(cmd_valid), 128'(0));
    chk("t3_nop_done", 128'(done_count), 128'(8));
    step();
    chk("t3_qc0", 128'(queue_count), 128'(0));
    chk("t3_rect_valid", 128'(cmd_valid), 128'(1));
    chk("t3_rect_data", cmd_data, rect);
    step();
    engine_done = 1;
    step();
    engine_done = 0;
    chk("t3_done", 128'(done_count), 128'(9));

    // watchdog: timeout 8 cycles after entering WAIT
    host_valid = 1;
    host_data = t1;
    step();
    host_data = t2;
    step();
    host_valid = 0;
    step();
    for (int i = 0; i < 7; i++) step();
    chk("t4_err_early", 128'(err_timeout), 128'(0));
    step();
    chk("t4_err_set", 128'(err_timeout), 128'(1));
    chk("t4_no_done", 128'(done_count), 128'(9));
    step();
    chk("t4_next_valid", 128'(cmd_valid), 128'(1));
    chk("t4_next_data", cmd_data, t2);
    step();
    engine_done = 1;
    step();
    engine_done = 0;
    chk("t4_next_done", 128'(done_count), 128'(10));
    chk("t4_err_sticky", 128'(err_timeout), 128'(1));
    err_clr = 1;
    step();
    err_clr = 0;
    chk("t4_err_clr", 128'(err_timeout), 128'(0));
    // completion on the timeout edge wins
    push(t3);
    step();
    step();
    for (int i = 0; i < 7; i++) step();
    engine_done = 1;
    step();
    engine_done = 0;
    chk("t4_tie_done", 128'(done_count), 128'(11));
    chk("t4_tie_err", 128'(err_timeout), 128'(0));

    // flush during WAIT
    host_valid = 1;
    for (int i = 0; i < 4; i++) begin
      host_data = mk(4'h7, 60 + i);
      step();
    end
    chk("t5_qc3", 128'(queue_count), 128'(3));
    host_data = mk(4'h7, 64);
    flush = 1;
    #1;
    chk("t5_flush_ready", 128'(host_ready), 128'(0));
    step();
    flush = 0;
    host_valid = 0;
    chk("t5_qc0", 128'(queue_count), 128'(0));
    chk("t5_busy_wait", 128'(busy), 128'(1));
    engine_done = 1;
    step();
    engine_done = 0;
    chk("t5_done", 128'(done_count), 128'(12));
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      seen += int'(cmd_valid);
      step();
    end
    chk("t5_no_issue", 128'(seen), 128'(0));
    chk("t5_idle", 128'(busy), 128'(0));

    // asynchronous reset mid-WAIT with two queued
    host_valid = 1;
    for (int i = 0; i < 3; i++) begin
      host_data = mk(4'h8, 70 + i);
      step();
    end
    host_valid = 0;
    chk("t6_qc2", 128'(queue_count), 128'(2));
    #2 rst = 1;
    #1;
    chk("t6_valid", 128'(cmd_valid), 128'(0));
    chk("t6_qc", 128'(queue_count), 128'(0));
    chk("t6_done", 128'(done_count), 128'(0));
    chk("t6_err", 128'(err_timeout), 128'(0));
    chk("t6_busy", 128'(busy), 128'(0));
    step();
    rst = 0;
    engine_done = 1;
    step();
    engine_done = 0;
    chk("t6_done_ignored", 128'(done_count), 128'(0));
    chk("t6_idle", 128'(busy), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
